decodificador_siete_segmentos: RTL and testbench



---
 rtl/decodificador_siete_segmentos.sv | 160 ++++++++++++++++
 tb/tb_decodificador_siete_segmentos.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_siete_segmentos.sv
// Seven-segment bus snooper: recovers the hex value shown on a 4-digit multiplexed
// display (active-low segments and anodes) with settle timing and repeat filtering.
module decodificador_siete_segmentos #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CONFIRM    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] valor,
  output logic [3:0]  valido,
  output logic [3:0]  error,
  output logic        nuevo
);

  localparam int unsigned DW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned CW = $clog2(CONFIRM + 1);
  localparam logic [6:0]  BLANK = 7'b1111111;

  logic [6:0]    seg_m, seg_s;
  logic [3:0]    an_m, an_s, an_prev;
  logic [DW-1:0] dwell_q, dwell_c;
  logic [6:0]    cand_q [4];
  logic [CW-1:0] cnt_q  [4];

  logic          onehot_c;
  logic [1:0]    dig_c;
  logic          sample_c;
  logic [3:0]    hex_c;
  logic          is_hex_c;
  logic          is_blank_c;
  logic [6:0]    cur_cand_c;
  logic [CW-1:0] cur_cnt_c;
  logic [CW-1:0] next_cnt_c;
  logic          cnt_full_c;
  logic          commit_c;
  logic [15:0]   valor_c;
  logic [3:0]    valido_c;
  logic [3:0]    error_c;
  logic          nuevo_c;

  // Anode decode: only a single low anode selects a digit.
  always_comb begin
    onehot_c = 1'b0;
    dig_c    = 2'd0;
    case (an_s)
      4'b1110: begin onehot_c = 1'b1; dig_c = 2'd0; end
      4'b1101: begin onehot_c = 1'b1; dig_c = 2'd1; end
      4'b1011: begin onehot_c = 1'b1; dig_c = 2'd2; end
      4'b0111: begin onehot_c = 1'b1; dig_c = 2'd3; end
      default: begin onehot_c = 1'b0; dig_c = 2'd0; end
    endcase
  end

  // Dwell counter reflects the current cycle's position in the dwell, so the
  // first cycle of a new selection is position 0 and sampling fires once.
  always_comb begin
    dwell_c = '0;
    if (onehot_c && (an_s == an_prev)) begin
      if (dwell_q == DW'(SETTLE_CYC)) dwell_c = dwell_q;
      else                            dwell_c = dwell_q + DW'(1);
    end
    sample_c = onehot_c && (dwell_c == DW'(SETTLE_CYC - 1));
  end

  // Inverse of the hex-to-segment table.
  always_comb begin
    hex_c      = 4'h0;
    is_hex_c   = 1'b1;
    is_blank_c = 1'b0;
    case (seg_s)
      7'b1000000: hex_c = 4'h0;
      7'b1111001: hex_c = 4'h1;
      7'b0100100: hex_c = 4'h2;
      7'b0110000: hex_c = 4'h3;
      7'b0011001: hex_c = 4'h4;
      7'b0010010: hex_c = 4'h5;
      7'b0000010: hex_c = 4'h6;
      7'b1111000: hex_c = 4'h7;
      7'b0000000: hex_c = 4'h8;
      7'b0010000: hex_c = 4'h9;
      7'b0001000: hex_c = 4'hA;
      7'b0000011: hex_c = 4'hB;
      7'b1000110: hex_c = 4'hC;
      7'b0100001: hex_c = 4'hD;
      7'b0000110: hex_c = 4'hE;
      7'b0001110: hex_c = 4'hF;
      BLANK: begin
        is_hex_c   = 1'b0;
        is_blank_c = 1'b1;
      end
      default: is_hex_c = 1'b0;
    endcase
  end

  // Repeat-confirmation filter: commit only on the sample that reaches CONFIRM.
  always_comb begin
    cur_cand_c = cand_q[dig_c];
    cur_cnt_c  = cnt_q[dig_c];
    cnt_full_c = (cur_cnt_c == CW'(CONFIRM));
    next_cnt_c = CW'(1);
    commit_c   = 1'b0;
    if (seg_s == cur_cand_c) begin
      next_cnt_c = cnt_full_c ? cur_cnt_c : cur_cnt_c + CW'(1);
      commit_c   = sample_c && !cnt_full_c && (next_cnt_c == CW'(CONFIRM));
    end else begin
      next_cnt_c = CW'(1);
      commit_c   = sample_c && (CONFIRM == 1);
    end
  end

  // Next output values and change pulse for a commit.
  always_comb begin
    valor_c  = valor;
    valido_c = valido;
    error_c  = error;
    if (commit_c) begin
      if (is_hex_c) valor_c[{dig_c, 2'b00} +: 4] = hex_c;
      valido_c[dig_c] = is_hex_c;
      error_c[dig_c]  = !is_hex_c && !is_blank_c;
    end
    nuevo_c = commit_c && ({valor_c, valido_c, error_c} != {valor, valido, error});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_m   <= BLANK;
      seg_s   <= BLANK;
      an_m    <= 4'b1111;
      an_s    <= 4'b1111;
      an_prev <= 4'b1111;
      dwell_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cand_q[i] <= BLANK;
        cnt_q[i]  <= '0;
      end
      valor   <= '0;
      valido  <= '0;
      error   <= '0;
      nuevo   <= 1'b0;
    end else begin
      seg_m   <= seg_in;
      seg_s   <= seg_m;
      an_m    <= an_in;
      an_s    <= an_m;
      an_prev <= an_s;
      dwell_q <= dwell_c;
      if (sample_c) begin
        cand_q[dig_c] <= seg_s;
        cnt_q[dig_c]  <= next_cnt_c;
      end
      valor   <= valor_c;
      valido  <= valido_c;
      error   <= error_c;
      nuevo   <= nuevo_c;
    end
  end

endmodule

// File: tb/tb_decodificador_siete_segmentos.sv
// Scoreboard bench for the seven-segment snooper: dwell-level reference model feeds
// an expected-update queue, a negedge monitor pops on every nuevo pulse.
module tb_decodificador_siete_segmentos;

  localparam int SETTLE  = 4;
  localparam int CONFIRM = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] valor;
  logic [3:0]  valido;
  logic [3:0]  error;
  logic        nuevo;

  decodificador_siete_segmentos #(.SETTLE_CYC(SETTLE), .CONFIRM(CONFIRM)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .valor(valor), .valido(valido), .error(error), .nuevo(nuevo)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int checks = 0;
  int errors = 0;
  int nuevo_seen = 0;
  int nuevo_exp = 0;

  logic [23:0] exp_q [$];
  logic [6:0]  m_cand [4];
  int          m_cnt  [4];
  logic [15:0] m_valor;
  logic [3:0]  m_valido;
  logic [3:0]  m_error;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (hex_pat[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cand[i] = 7'h7F;
      m_cnt[i]  = 0;
    end
    m_valor = '0; m_valido = '0; m_error = '0;
    exp_q.delete();
  endtask

  // One sample of digit d showing pattern p, as the display rules describe it.
  task automatic model_sample(input int d, input logic [6:0] p);
    bit commit = 0;
    int h;
    logic [15:0] nv;
    logic [3:0] nvd, ne;
    if (p == m_cand[d]) begin
      if (m_cnt[d] < CONFIRM) begin
        m_cnt[d]++;
        commit = (m_cnt[d] == CONFIRM);
      end
    end else begin
      m_cand[d] = p;
      m_cnt[d]  = 1;
      commit = (CONFIRM == 1);
    end
    if (!commit) return;
    h = lookup(p);
    nv = m_valor; nvd = m_valido; ne = m_error;
    if (h >= 0) begin
      nv[d*4 +: 4] = 4'(h); nvd[d] = 1'b1; ne[d] = 1'b0;
    end else if (p == 7'h7F) begin
      nvd[d] = 1'b0; ne[d] = 1'b0;
    end else begin
      nvd[d] = 1'b0; ne[d] = 1'b1;
    end
    if ({nv, nvd, ne} != {m_valor, m_valido, m_error}) begin
      exp_q.push_back({nv, nvd, ne});
      nuevo_exp++;
    end
    m_valor = nv; m_valido = nvd; m_error = ne;
  endtask

  // Hold one anode selection for len cycles, then a one-cycle idle gap.
  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int len);
    logic [3:0] low = ~an;
    if (len >= SETTLE && $countones(low) == 1) begin
      for (int i = 0; i < 4; i++) if (low[i]) model_sample(i, seg);
    end
    an_in = an;
    seg_in = seg;
    repeat (len) @(negedge clk);
    an_in = 4'hF;
    seg_in = 7'h7F;
    @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] p0, p1, p2, p3, input int len);
    dwell(4'b1110, p0, len);
    dwell(4'b1101, p1, len);
    dwell(4'b1011, p2, len);
    dwell(4'b0111, p3, len);
  endtask

  task automatic drain();
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    an_in = 4'hF; seg_in = 7'h7F;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: every nuevo pulse must match the next expected update.
  always @(negedge clk) begin
    if (!rst && nuevo) begin
      nuevo_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_nuevo: got %0h with nothing expected", {valor, valido, error});
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({valor, valido, error} !== e) begin
          errors++;
          $display("FAIL update: got %0h expected %0h", {valor, valido, error}, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    logic [6:0] cur [4];
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valor", 32'(valor), 32'h0);
    chk("rst_valido", 32'(valido), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_nuevo", 32'(nuevo), 32'h0);

    // Scan 1,2,3,4.
    n0 = nuevo_seen;
    scan(hex_pat[1], hex_pat[2], hex_pat[3], hex_pat[4], 8);
    scan(hex_pat[1], hex_pat[2], hex_pat[3], hex_pat[4], 8);
    drain();
    chk("scan_valor", 32'(valor), 32'h4321);
    chk("scan_valido", 32'(valido), 32'hF);
    chk("scan_error", 32'(error), 32'h0);
    scan(hex_pat[1], hex_pat[2], hex_pat[3], hex_pat[4], 8);
    drain();
    chk("scan_nuevo_count", 32'(nuevo_seen - n0), 32'd4);

    // Alternating F/E on digit 0 never confirms.
    do_reset();
    for (int k = 0; k < 4; k++) dwell(4'b1110, (k % 2 == 0) ? hex_pat[15] : hex_pat[14], 8);
    drain();
    chk("alt_valido0", 32'(valido[0]), 32'h0);
    chk("alt_valor", 32'(valor), 32'h0);

    // Unrecognised then A on digit 2.
    dwell(4'b1011, 7'b1010101, 8);
    dwell(4'b1011, 7'b1010101, 8);
    drain();
    chk("bad_error2", 32'(error[2]), 32'h1);
    chk("bad_valido2", 32'(valido[2]), 32'h0);
    chk("bad_nib2", 32'(valor[11:8]), 32'h0);
    dwell(4'b1011, hex_pat[10], 8);
    dwell(4'b1011, hex_pat[10], 8);
    drain();
    chk("a_nib2", 32'(valor[11:8]), 32'hA);
    chk("a_error2", 32'(error[2]), 32'h0);
    chk("a_valido2", 32'(valido[2]), 32'h1);

    // Short dwells and two active anodes: no sampling.
    n0 = nuevo_seen;
    for (int k = 0; k < 3; k++) dwell(4'b1110, hex_pat[7], 3);
    for (int k = 0; k < 3; k++) dwell(4'b1100, hex_pat[7], 8);
    drain();
    chk("short_valor", 32'(valor), 32'(m_valor));
    chk("short_valido", 32'(valido), 32'(m_valido));
    chk("short_error", 32'(error), 32'(m_error));
    chk("short_nuevo", 32'(nuevo_seen - n0), 32'd0);

    // Digit 1: 9 then blank.
    dwell(4'b1101, hex_pat[9], 8);
    dwell(4'b1101, hex_pat[9], 8);
    drain();
    chk("nine_nib1", 32'(valor[7:4]), 32'h9);
    n0 = nuevo_seen;
    dwell(4'b1101, 7'h7F, 8);
    dwell(4'b1101, 7'h7F, 8);
    drain();
    chk("blank_valido1", 32'(valido[1]), 32'h0);
    chk("blank_error1", 32'(error[1]), 32'h0);
    chk("blank_nib1", 32'(valor[7:4]), 32'h9);
    chk("blank_nuevo", 32'(nuevo_seen - n0), 32'd1);

    // BEEF, then reset in the middle of a dwell.
    scan(hex_pat[15], hex_pat[14], hex_pat[14], hex_pat[11], 8);
    scan(hex_pat[15], hex_pat[14], hex_pat[14], hex_pat[11], 8);
    drain();
    chk("beef_valor", 32'(valor), 32'hBEEF);
    an_in = 4'b1110; seg_in = hex_pat[5];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valor", 32'(valor), 32'h0);
    chk("mid_rst_valido", 32'(valido), 32'h0);
    chk("mid_rst_error", 32'(error), 32'h0);
    chk("mid_rst_nuevo", 32'(nuevo), 32'h0);
    rst = 1'b0;
    an_in = 4'hF; seg_in = 7'h7F;
    model_reset();
    drain();
    dwell(4'b1110, hex_pat[1], 8);
    drain();
    chk("post_rst_one_dwell", 32'(valor), 32'h0);
    dwell(4'b1110, hex_pat[1], 8);
    drain();
    chk("post_rst_two_dwells", 32'(valor), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 4; i++) cur[i] = hex_pat[$urandom_range(0, 15)];
    for (int k = 0; k < 300; k++) begin
      int d, r;
      logic [3:0] an;
      d = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 19);
        if (r < 14)      cur[d] = hex_pat[$urandom_range(0, 15)];
        else if (r < 17) cur[d] = 7'h7F;
        else             cur[d] = 7'($urandom);
      end
      an = 4'hF;
      an[d] = 1'b0;
      if ($urandom_range(0, 9) == 0) an = 4'($urandom);
      dwell(an, cur[d], $urandom_range(1, 9));
    end
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_valor", 32'(valor), 32'(m_valor));
    chk("final_valido", 32'(valido), 32'(m_valido));
    chk("final_error", 32'(error), 32'(m_error));
    chk("final_nuevo_count", 32'(nuevo_seen), 32'(nuevo_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
